// File: rtl/lcd12864_ctrl_if.sv
// Host-side frame-buffer write bus for lcd12864_ctrl.
// The host drives one byte per clk. The controller only ever listens.
interface lcd12864_ctrl_if;
    logic       wr_en;
    logic [5:0] wr_addr;   // {row[1:0], col[3:0]}
    logic [7:0] wr_data;   // character code

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/lcd12864_ctrl.sv
// ST7920 (LCD12864) character-mode controller in 8-bit parallel, write-only mode.
// - Paces one LCD transaction per period of the slow lcd_clk strobe:
//     * lcd_en rises with new RS/DB on the synchronised rising edge.
//     * lcd_en falls on the synchronised falling edge.
// - Sends the init commands once. It then streams the 4x16 frame buffer row by row.
//   Each row is preceded by its DDRAM address command.
// - Build option LCD12864_INIT_CLEAR_EN:
//     * Defined: the display-clear command (0x01) is part of init.
//     * Undefined (default): init is 0x30, 0x0C, 0x06.
module lcd12864_ctrl #(
    parameter int REFRESH_LOOP = 1      // 1: refresh forever, 0: stop after first frame
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           lcd_clk,
    lcd12864_ctrl_if.slave host,
    output logic           lcd_rs,
    output logic           lcd_rw,
    output logic           lcd_en,
    output logic [7:0]     lcd_data,
    output logic           lcd_psb,
    output logic           busy,
    output logic           frame_done
);

`ifdef LCD12864_INIT_CLEAR_EN
    localparam logic [1:0]      INIT_LAST = 2'd3;
    localparam logic [3:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h30};
`else
    localparam logic [1:0]      INIT_LAST = 2'd2;
    localparam logic [3:0][7:0] INIT_CMDS = {8'h00, 8'h06, 8'h0C, 8'h30};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROW_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t     r_state, w_state_nx;
    logic [1:0] r_row, w_row_nx;
    logic [3:0] r_col, w_col_nx;
    logic [1:0] r_init_idx, w_init_idx_nx;
    logic       r_rs, w_rs_nx;
    logic       r_en, w_en_nx;
    logic [7:0] r_data, w_data_nx;
    logic       r_busy, w_busy_nx;
    logic       r_frame_done, w_frame_done_nx;
    // The last byte of a frame is in flight. frame_done fires when it ends.
    logic       r_frame_end, w_frame_end_nx;

    logic [7:0] r_buf [0:63];

    logic       r_sync1, r_sync2, r_sync_q;
    logic       w_rise_tick, w_fall_tick;

    // DDRAM start address of each text row. Rows 2/3 continue rows 0/1 in ST7920 memory.
    function automatic logic [7:0] row_cmd(input logic [1:0] row);
        case (row)
            2'd0:    row_cmd = 8'h80;
            2'd1:    row_cmd = 8'h90;
            2'd2:    row_cmd = 8'h88;
            default: row_cmd = 8'h98;
        endcase
    endfunction

    // Bring lcd_clk into the clk domain. Keep one more stage of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_sync1  <= lcd_clk;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
        end
    end

    assign w_rise_tick = r_sync2 & ~r_sync_q;
    assign w_fall_tick = ~r_sync2 & r_sync_q;

    // Frame buffer: host writes land in any state. Reset blanks the screen to spaces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) r_buf[i] <= 8'h20;
        end else if (host.wr_en) begin
            r_buf[host.wr_addr] <= host.wr_data;
        end
    end

    // Sequencer: a rising tick launches a transaction, and a falling tick closes it.
    always_comb begin
        w_state_nx      = r_state;
        w_row_nx        = r_row;
        w_col_nx        = r_col;
        w_init_idx_nx   = r_init_idx;
        w_rs_nx         = r_rs;
        w_en_nx         = r_en;
        w_data_nx       = r_data;
        w_busy_nx       = r_busy;
        w_frame_done_nx = 1'b0;
        w_frame_end_nx  = r_frame_end;

        if (w_fall_tick) begin
            w_en_nx = 1'b0;
            if (r_frame_end) begin
                w_frame_end_nx  = 1'b0;
                w_frame_done_nx = 1'b1;
                // A single-shot build parks only after the last strobe has closed.
                if (REFRESH_LOOP == 0) begin
                    w_state_nx = S_DONE;
                    w_busy_nx  = 1'b0;
                end
            end
        end else if (w_rise_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_rs_nx       = 1'b0;
                    w_data_nx     = INIT_CMDS[0];
                    w_en_nx       = 1'b1;
                    w_busy_nx     = 1'b1;
                    w_init_idx_nx = 2'd1;
                    w_state_nx    = S_INIT;
                end
                S_INIT: begin
                    w_rs_nx   = 1'b0;
                    w_data_nx = INIT_CMDS[r_init_idx];
                    w_en_nx   = 1'b1;
                    if (r_init_idx == INIT_LAST) w_state_nx = S_ROW_ADDR;
                    else                         w_init_idx_nx = r_init_idx + 2'd1;
                end
                S_ROW_ADDR: begin
                    w_rs_nx    = 1'b0;
                    w_data_nx  = row_cmd(r_row);
                    w_en_nx    = 1'b1;
                    w_col_nx   = 4'd0;
                    w_state_nx = S_DATA;
                end
                S_DATA: begin
                    // Sampled on this edge, so a same-edge host write shows up one frame later.
                    w_rs_nx   = 1'b1;
                    w_data_nx = r_buf[{r_row, r_col}];
                    w_en_nx   = 1'b1;
                    if (r_col == 4'd15) begin
                        w_col_nx   = 4'd0;
                        w_row_nx   = r_row + 2'd1;
                        w_state_nx = S_ROW_ADDR;
                        if (r_row == 2'd3) w_frame_end_nx = 1'b1;
                    end else begin
                        w_col_nx = r_col + 4'd1;
                    end
                end
                default: ;  // S_DONE ignores the strobe until reset
            endcase
        end
    end

    // State and output registers. Async reset clears lcd_en without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_row        <= 2'd0;
            r_col        <= 4'd0;
            r_init_idx   <= 2'd0;
            r_rs         <= 1'b0;
            r_en         <= 1'b0;
            r_data       <= 8'h00;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_end  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_row        <= w_row_nx;
            r_col        <= w_col_nx;
            r_init_idx   <= w_init_idx_nx;
            r_rs         <= w_rs_nx;
            r_en         <= w_en_nx;
            r_data       <= w_data_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_frame_done_nx;
            r_frame_end  <= w_frame_end_nx;
        end
    end

    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = r_en;
    assign lcd_data   = r_data;
    assign lcd_psb    = 1'b1;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd12864_ctrl.sv
// Bench for lcd12864_ctrl: a refreshing instance plus a single-shot instance on one host bus.
// Each LCD strobe is compared with a frame-level model of what the screen should show.
module tb_lcd12864_ctrl;
`ifdef LCD12864_INIT_CLEAR_EN
    localparam int INIT_N = 4;
`else
    localparam int INIT_N = 3;
`endif
    localparam int FRAME_N = 68;
    localparam int HALF    = 20;
    localparam int NV      = 14;
    localparam int LOGN    = 512;

    logic       clk, rst_n, lcd_clk;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_psb, busy, frame_done;
    logic [7:0] lcd_data;
    logic       rs0, rw0, en0, psb0, busy0, fd0;
    logic [7:0] data0;

    lcd12864_ctrl_if bus();

    lcd12864_ctrl #(.REFRESH_LOOP(1)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_clk(lcd_clk), .host(bus),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .lcd_psb(lcd_psb), .busy(busy), .frame_done(frame_done)
    );

    lcd12864_ctrl #(.REFRESH_LOOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .lcd_clk(lcd_clk), .host(bus),
        .lcd_rs(rs0), .lcd_rw(rw0), .lcd_en(en0), .lcd_data(data0),
        .lcd_psb(psb0), .busy(busy0), .frame_done(fd0)
    );

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         txn;
        logic       exp_rs;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] init_tab [0:3];
    logic [7:0] model_buf [0:63];
    logic       log_rs [0:LOGN-1];
    logic [7:0] log_data [0:LOGN-1];

    int   checks = 0, failures = 0;
    int   cyc = 0, t_lrise = 0, txn_cnt = 0, hi_cnt = 0;
    int   en0_rises = 0, fd0_hi = 0;
    logic lcd_run = 1'b0;
    logic en_prev = 1'b0, en0_prev = 1'b0;
    logic hold_rs = 1'b0, hold_bad = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic pend_v = 1'b0;
    logic [5:0] pend_a = 6'd0;
    logic [7:0] pend_d = 8'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running 40-clk lcd_clk once enabled. The rising-edge time is noted for the latency check.
    initial begin
        int ph;
        ph = 0;
        lcd_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_run) begin
                if (ph == HALF - 1) begin
                    ph = 0;
                    lcd_clk = ~lcd_clk;
                    if (lcd_clk) t_lrise = cyc;
                end else begin
                    ph++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // What the screen should receive as transaction k since reset, from the current buffer contents.
    function automatic logic [8:0] exp_txn(input int k);
        int j, r, c;
        logic [7:0] base;
        if (k < INIT_N) return {1'b0, init_tab[k]};
        j = (k - INIT_N) % FRAME_N;
        r = j / 17;
        c = j % 17;
        if (c == 0) begin
            base = 8'h80;
            if (r % 2 == 1) base = base + 8'h10;
            if (r >= 2)     base = base + 8'h08;
            return {1'b0, base};
        end
        return {1'b1, model_buf[r * 16 + c - 1]};
    endfunction

    function automatic logic is_frame_end(input int k);
        return (k >= INIT_N) && (((k - INIT_N) % FRAME_N) == FRAME_N - 1);
    endfunction

    // Record any host write committed on this edge. It enters the model after this edge's display check.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        pend_v <= rst_n && bus.wr_en;
        pend_a <= bus.wr_addr;
        pend_d <= bus.wr_data;
    end

    // Monitor for the refreshing instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) model_buf[i] <= 8'h20;
            txn_cnt <= 0;
            hi_cnt  <= 0;
            en_prev <= 1'b0;
        end else begin
            if (lcd_en && !en_prev) begin
                chk("txn", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_txn(txn_cnt)});
                chk("latency", cyc - t_lrise, 3);
                if (txn_cnt < LOGN) begin
                    log_rs[txn_cnt]   <= lcd_rs;
                    log_data[txn_cnt] <= lcd_data;
                end
                txn_cnt  <= txn_cnt + 1;
                hi_cnt   <= 1;
                hold_rs  <= lcd_rs;
                hold_d   <= lcd_data;
                hold_bad <= 1'b0;
            end else if (lcd_en) begin
                hi_cnt <= hi_cnt + 1;
                if ({lcd_rs, lcd_data} !== {hold_rs, hold_d}) hold_bad <= 1'b1;
            end
            if (!lcd_en && en_prev) begin
                chk("en_width", hi_cnt, HALF);
                chk("hold", {hold_bad, lcd_rs, lcd_data}, {1'b0, hold_rs, hold_d});
                chk("frame_done", frame_done, is_frame_end(txn_cnt - 1));
            end else if (frame_done) begin
                chk("frame_done_stray", frame_done, 1'b0);
            end
            if (pend_v) model_buf[pend_a] <= pend_d;
            en_prev <= lcd_en;
        end
    end

    // Counters for the single-shot instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            en0_rises <= 0;
            fd0_hi    <= 0;
            en0_prev  <= 1'b0;
        end else begin
            if (en0 && !en0_prev) en0_rises <= en0_rises + 1;
            if (fd0) fd0_hi <= fd0_hi + 1;
            en0_prev <= en0;
        end
    end

    task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_txn(input int tgt);
        int n;
        n = 0;
        while (txn_cnt < tgt && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_txn", txn_cnt >= tgt, 1'b1);
    endtask

    task automatic set_vec(input int i, input logic we, input logic [5:0] a, input logic [7:0] wd,
                           input int t, input logic rs, input logic [7:0] d);
        vecs[i] = '{we, a, wd, t, rs, d};
    endtask

    initial begin
        int k, t;
        logic [5:0] ra;
        init_tab[0] = 8'h30;
        init_tab[1] = 8'h0C;
`ifdef LCD12864_INIT_CLEAR_EN
        init_tab[2] = 8'h01;
        init_tab[3] = 8'h06;
`else
        init_tab[2] = 8'h06;
        init_tab[3] = 8'h00;
`endif
        // {write?, addr, wdata, transaction index, expected RS, expected DB}
        set_vec(0,  1'b0, 6'h00, 8'h00, 0,                      1'b0, 8'h30);
        set_vec(1,  1'b0, 6'h00, 8'h00, 1,                      1'b0, 8'h0C);
        set_vec(2,  1'b0, 6'h00, 8'h00, INIT_N - 1,             1'b0, 8'h06);
        set_vec(3,  1'b0, 6'h00, 8'h00, INIT_N,                 1'b0, 8'h80);
        set_vec(4,  1'b1, 6'h00, 8'h41, INIT_N + 1,             1'b1, 8'h41);
        set_vec(5,  1'b0, 6'h00, 8'h00, INIT_N + 2,             1'b1, 8'h20);
        set_vec(6,  1'b1, 6'h0F, 8'hC3, INIT_N + 16,            1'b1, 8'hC3);
        set_vec(7,  1'b0, 6'h00, 8'h00, INIT_N + 17,            1'b0, 8'h90);
        set_vec(8,  1'b1, 6'h10, 8'h55, INIT_N + 18,            1'b1, 8'h55);
        set_vec(9,  1'b0, 6'h00, 8'h00, INIT_N + 34,            1'b0, 8'h88);
        set_vec(10, 1'b1, 6'h2A, 8'h7E, INIT_N + 45,            1'b1, 8'h7E);
        set_vec(11, 1'b0, 6'h00, 8'h00, INIT_N + 51,            1'b0, 8'h98);
        set_vec(12, 1'b1, 6'h3F, 8'h5A, INIT_N + FRAME_N - 1,   1'b1, 8'h5A);
        set_vec(13, 1'b0, 6'h00, 8'h00, INIT_N + FRAME_N,       1'b0, 8'h80);

        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 6'd0;
        bus.wr_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_psb", lcd_psb, 1'b1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_en", lcd_en, 1'b0);

        // Random pre-frame fill. The table writes follow, so their bytes win.
        for (int i = 0; i < 24; i++) begin
            ra = 6'($urandom_range(2, 63));
            host_wr(ra, 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < NV; i++)
            if (vecs[i].we) host_wr(vecs[i].addr, vecs[i].wdata);

        lcd_run = 1'b1;
        wait_txn(INIT_N + FRAME_N + 1);
        for (int i = 0; i < NV; i++)
            chk($sformatf("vec%0d", i), {23'd0, log_rs[vecs[i].txn], log_data[vecs[i].txn]},
                {23'd0, vecs[i].exp_rs, vecs[i].exp_data});
        chk("busy_run", busy, 1'b1);

        // Random host traffic while the display is being refreshed.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 6'($urandom_range(0, 63));
                bus.wr_data = 8'($urandom_range(0, 255));
            end else begin
                bus.wr_en = 1'b0;
            end
        end
        @(negedge clk);
        bus.wr_en = 1'b0;

        // Write addr 0x05 on the edge that samples it. The old byte shows now, the new one next frame.
        host_wr(6'h05, 8'h77);
        k = INIT_N + 6;
        while (k <= txn_cnt + 1) k += FRAME_N;
        wait_txn(k);
        @(posedge lcd_clk);
        repeat (2) @(negedge clk);
        host_wr(6'h05, 8'h33);
        wait_txn(k + 1);
        chk("same_cycle_old", log_data[k], 8'h77);
        wait_txn(k + FRAME_N + 1);
        chk("same_cycle_new", log_data[k + FRAME_N], 8'h33);

        // The single-shot instance stopped after one frame and stayed quiet since.
        chk("done_busy", busy0, 1'b0);
        chk("done_en", en0, 1'b0);
        chk("done_pulses", en0_rises, INIT_N + FRAME_N);
        chk("done_fd_cycles", fd0_hi, 1);
        chk("done_last", {rs0, data0}, {1'b1, 8'h5A});
        chk("done_rw_psb", {rw0, psb0}, 2'b01);

        // Reset in the middle of a data strobe.
        t = txn_cnt + 2;
        while (((t - 1 - INIT_N) % 17) == 0) t++;
        wait_txn(t);
        chk("pre_rst_en", lcd_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", lcd_en, 1'b0);
        chk("async_rs_data", {lcd_rs, lcd_data}, 9'h000);
        chk("async_busy_fd", {busy, frame_done}, 2'b00);
        chk("async_rw_psb", {lcd_rw, lcd_psb}, 2'b01);
        @(negedge lcd_clk);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_txn(INIT_N + 3);
        chk("restart_cmd0", {log_rs[0], log_data[0]}, {1'b0, 8'h30});
        chk("restart_row0", log_data[INIT_N], 8'h80);
        chk("refill_addr0", log_data[INIT_N + 1], 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
